uart_param: RTL and testbench

Parametrised single-clock UART core: transmitter, oversampling receiver and baud divider in one block, with configurable data width, parity and stop bits. Placed between a register/host interface and the device pins. Replaces the fixed 8-bit, dual-clock transmit/receive pair, and adds line-error detection and a busy/ready handshake.

---
 rtl/uart_param.sv | 215 +++++++++++++++++++++
 tb/tb_uart_param.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_param.sv
// uart_param: single-clock UART (TX, 16x oversampling RX, independent baud dividers); SEND is taken only while BUSY=0.
// Accept to TXD start bit is 1 cycle; the optional LOOPBACK port is present only when UART_LOOPBACK_EN is defined.
module uart_param #(
  parameter int DIVISOR   = 27,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       send,
  input  logic [7:0] tx_data,
  output logic       busy,
  output logic       ninto,
  output logic       txd,
  input  logic       rxd,
`ifdef UART_LOOPBACK_EN
  input  logic       loopback,
`endif
  output logic [7:0] rx_data,
  output logic       rx_perr,
  output logic       rx_ferr,
  output logic       ninti
);

  localparam logic [15:0] DIV_LAST  = 16'(DIVISOR - 1);
  localparam logic [2:0]  LAST_DATA = 3'(DATA_BITS - 1);
  localparam logic [2:0]  LAST_STOP = 3'(STOP_BITS - 1);
  localparam logic [7:0]  DATA_MASK = 8'((1 << DATA_BITS) - 1);
  localparam logic        ODD       = (PARITY == 1);
  localparam logic        HAS_PAR   = (PARITY != 0);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

  state_t      tx_state, tx_state_n;
  logic [15:0] tx_div, tx_div_n;
  logic [3:0]  tx_tk, tx_tk_n;
  logic [2:0]  tx_cnt, tx_cnt_n;
  logic [7:0]  tx_sh, tx_sh_n;
  logic        tx_par, tx_par_n, tx_bit, tx_bit_n;
  logic        tx_tick, tx_bit_end, tx_done;

  always_comb begin
    tx_state_n = tx_state;
    tx_cnt_n   = tx_cnt;
    tx_sh_n    = tx_sh;
    tx_par_n   = tx_par;
    tx_bit_n   = tx_bit;
    tx_done    = 1'b0;
    tx_tick    = (tx_div == DIV_LAST);
    tx_bit_end = tx_tick && (tx_tk == 4'd15);
    // Divider and tick count are held at zero in IDLE so every frame starts phase-aligned to its accept.
    if (tx_state == S_IDLE) begin
      tx_div_n = '0;
      tx_tk_n  = '0;
    end else begin
      tx_div_n = tx_tick ? 16'd0 : tx_div + 16'd1;
      tx_tk_n  = tx_tk + {3'b000, tx_tick};
    end
    case (tx_state)
      S_IDLE: if (send) begin
        tx_state_n = S_START;
        tx_sh_n    = tx_data & DATA_MASK;
        tx_par_n   = ^(tx_data & DATA_MASK) ^ ODD;
        tx_bit_n   = 1'b0;
      end
      S_START: if (tx_bit_end) begin
        tx_state_n = S_DATA;
        tx_bit_n   = tx_sh[0];
        tx_sh_n    = tx_sh >> 1;
        tx_cnt_n   = '0;
      end
      S_DATA: if (tx_bit_end) begin
        if (tx_cnt == LAST_DATA) begin
          tx_cnt_n   = '0;
          tx_state_n = HAS_PAR ? S_PAR : S_STOP;
          tx_bit_n   = HAS_PAR ? tx_par : 1'b1;
        end else begin
          tx_cnt_n = tx_cnt + 3'd1;
          tx_bit_n = tx_sh[0];
          tx_sh_n  = tx_sh >> 1;
        end
      end
      S_PAR: if (tx_bit_end) begin
        tx_state_n = S_STOP;
        tx_bit_n   = 1'b1;
      end
      S_STOP: if (tx_bit_end) begin
        if (tx_cnt == LAST_STOP) begin
          tx_state_n = S_IDLE;
          tx_done    = 1'b1;
        end else begin
          tx_cnt_n = tx_cnt + 3'd1;
        end
      end
      default: tx_state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tx_state <= S_IDLE;
      tx_div   <= '0;
      tx_tk    <= '0;
      tx_cnt   <= '0;
      tx_sh    <= '0;
      tx_par   <= 1'b0;
      tx_bit   <= 1'b1;
    end else begin
      tx_state <= tx_state_n;
      tx_div   <= tx_div_n;
      tx_tk    <= tx_tk_n;
      tx_cnt   <= tx_cnt_n;
      tx_sh    <= tx_sh_n;
      tx_par   <= tx_par_n;
      tx_bit   <= tx_bit_n;
    end
  end

  assign busy  = (tx_state != S_IDLE);
  assign ninto = ~tx_done;

  logic        rx_s1, rx_s2, rx_prev, rx_in;
  state_t      rx_state, rx_state_n;
  logic [15:0] rx_div;
  logic [3:0]  rx_tk, rx_tk_n;
  logic [2:0]  rx_cnt, rx_cnt_n;
  logic [7:0]  rx_sh, rx_sh_n;
  logic        rx_pbit, rx_pbit_n, rx_tick, rx_sample, rx_done;

`ifdef UART_LOOPBACK_EN
  assign txd   = loopback ? 1'b1 : tx_bit;
  assign rx_in = loopback ? tx_bit : rx_s2;
`else
  assign txd   = tx_bit;
  assign rx_in = rx_s2;
`endif

  always_comb begin
    rx_state_n = rx_state;
    rx_cnt_n   = rx_cnt;
    rx_sh_n    = rx_sh;
    rx_pbit_n  = rx_pbit;
    rx_done    = 1'b0;
    rx_tick    = (rx_div == DIV_LAST);
    rx_tk_n    = rx_tk + {3'b000, rx_tick};
    // Start bit is checked at its middle (8th tick); later bits every 16 ticks from there.
    rx_sample  = rx_tick && (rx_tk == ((rx_state == S_START) ? 4'd7 : 4'd15));
    case (rx_state)
      S_IDLE: begin
        rx_tk_n = '0;
        if (rx_prev && !rx_in) rx_state_n = S_START;
      end
      S_START: if (rx_sample) begin
        if (rx_in) begin
          rx_state_n = S_IDLE;
        end else begin
          rx_state_n = S_DATA;
          rx_tk_n    = '0;
          rx_cnt_n   = '0;
          rx_sh_n    = '0;
        end
      end
      S_DATA: if (rx_sample) begin
        rx_sh_n[rx_cnt] = rx_in;
        if (rx_cnt == LAST_DATA) rx_state_n = HAS_PAR ? S_PAR : S_STOP;
        else                     rx_cnt_n   = rx_cnt + 3'd1;
      end
      S_PAR: if (rx_sample) begin
        rx_pbit_n  = rx_in;
        rx_state_n = S_STOP;
      end
      S_STOP: if (rx_sample) begin
        rx_done    = 1'b1;
        rx_state_n = S_IDLE;
      end
      default: rx_state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_prev  <= 1'b1;
      rx_state <= S_IDLE;
      rx_div   <= '0;
      rx_tk    <= '0;
      rx_cnt   <= '0;
      rx_sh    <= '0;
      rx_pbit  <= 1'b0;
      rx_data  <= '0;
      rx_perr  <= 1'b0;
      rx_ferr  <= 1'b0;
      ninti    <= 1'b1;
    end else begin
      rx_s1    <= rxd;
      rx_s2    <= rx_s1;
      rx_prev  <= rx_in;
      rx_state <= rx_state_n;
      rx_div   <= rx_tick ? 16'd0 : rx_div + 16'd1;
      rx_tk    <= rx_tk_n;
      rx_cnt   <= rx_cnt_n;
      rx_sh    <= rx_sh_n;
      rx_pbit  <= rx_pbit_n;
      ninti    <= ~rx_done;
      if (rx_done) begin
        rx_data <= rx_sh;
        rx_perr <= HAS_PAR && (^rx_sh ^ rx_pbit ^ ODD);
        rx_ferr <= ~rx_in;
      end
    end
  end

endmodule

// File: tb/tb_uart_param.sv
// Bench for uart_param: an 8N1 instance (a_*) and a 7E1 instance (b_*), both with DIVISOR=4.
module tb_uart_param;

  typedef struct packed {
    logic [7:0] d;
    logic       p;
    logic       f;
  } rx_exp_t;

  logic clock, reset_n;
  logic a_send, a_busy, a_ninto, a_txd, a_rxd, a_rxd_drv, a_lb, a_rx_perr, a_rx_ferr, a_ninti;
  logic b_send, b_busy, b_ninto, b_txd, b_rxd, b_rxd_drv, b_lb, b_rx_perr, b_rx_ferr, b_ninti;
  logic [7:0] a_tx_data, a_rx_data, b_tx_data, b_rx_data;

  int total = 0;
  int bad = 0;
  int a_ninti_cnt = 0;
  int b_ninti_cnt = 0;
  int a_ninto_cnt = 0;
  rx_exp_t a_rxq[$];
  rx_exp_t b_rxq[$];
  logic    a_txq[$];
  rx_exp_t a_e, b_e;

  assign a_rxd = a_lb ? a_txd : a_rxd_drv;
  assign b_rxd = b_lb ? b_txd : b_rxd_drv;

  uart_param #(.DIVISOR(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_a (
    .clock(clock), .reset_n(reset_n), .send(a_send), .tx_data(a_tx_data),
    .busy(a_busy), .ninto(a_ninto), .txd(a_txd), .rxd(a_rxd),
    .rx_data(a_rx_data), .rx_perr(a_rx_perr), .rx_ferr(a_rx_ferr), .ninti(a_ninti));

  uart_param #(.DIVISOR(4), .DATA_BITS(7), .PARITY(2), .STOP_BITS(1)) u_b (
    .clock(clock), .reset_n(reset_n), .send(b_send), .tx_data(b_tx_data),
    .busy(b_busy), .ninto(b_ninto), .txd(b_txd), .rxd(b_rxd),
    .rx_data(b_rx_data), .rx_perr(b_rx_perr), .rx_ferr(b_rx_ferr), .ninti(b_ninti));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(negedge clock) if (a_ninto === 1'b0) a_ninto_cnt++;

  // Receive scoreboards: every NINTI pulse must match the oldest expected frame.
  always @(negedge clock) begin
    if (reset_n === 1'b1 && a_ninti === 1'b0) begin
      a_ninti_cnt++;
      total++;
      if (a_rxq.size() == 0) begin
        bad++;
        $display("FAIL a_unexpected_ninti: got data=%h perr=%b ferr=%b, required no pulse", a_rx_data, a_rx_perr, a_rx_ferr);
      end else begin
        a_e = a_rxq.pop_front();
        if ({a_rx_data, a_rx_perr, a_rx_ferr} !== a_e) begin
          bad++;
          $display("FAIL a_rx_frame: got data=%h perr=%b ferr=%b, required data=%h perr=%b ferr=%b",
                   a_rx_data, a_rx_perr, a_rx_ferr, a_e.d, a_e.p, a_e.f);
        end
      end
    end
  end

  always @(negedge clock) begin
    if (reset_n === 1'b1 && b_ninti === 1'b0) begin
      b_ninti_cnt++;
      total++;
      if (b_rxq.size() == 0) begin
        bad++;
        $display("FAIL b_unexpected_ninti: got data=%h perr=%b ferr=%b, required no pulse", b_rx_data, b_rx_perr, b_rx_ferr);
      end else begin
        b_e = b_rxq.pop_front();
        if ({b_rx_data, b_rx_perr, b_rx_ferr} !== b_e) begin
          bad++;
          $display("FAIL b_rx_frame: got data=%h perr=%b ferr=%b, required data=%h perr=%b ferr=%b",
                   b_rx_data, b_rx_perr, b_rx_ferr, b_e.d, b_e.p, b_e.f);
        end
      end
    end
  end

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    total++;
    if ({a_txd, a_busy, a_ninto, a_ninti} !== 4'b1011) begin
      bad++;
      $display("FAIL reset_a_ctl: got txd/busy/ninto/ninti=%b, required 1011", {a_txd, a_busy, a_ninto, a_ninti});
    end
    total++;
    if ({a_rx_data, a_rx_perr, a_rx_ferr} !== 10'h000) begin
      bad++;
      $display("FAIL reset_a_rx: got %h, required 000", {a_rx_data, a_rx_perr, a_rx_ferr});
    end
    total++;
    if ({b_txd, b_busy, b_ninto, b_ninti, b_rx_data, b_rx_perr, b_rx_ferr} !== 14'h2C00) begin
      bad++;
      $display("FAIL reset_b: got %h, required 2c00", {b_txd, b_busy, b_ninto, b_ninti, b_rx_data, b_rx_perr, b_rx_ferr});
    end
    @(negedge clock);
    reset_n = 1'b1;
    repeat (4) @(negedge clock);
  endtask

  // Sends one 8N1 frame on a_*, checking both ends of every bit, the NINTO cycle and BUSY release.
  // A second SEND with different data is attempted mid-frame and must be ignored.
  task automatic check_tx_frame(input logic [7:0] data);
    logic [9:0] frame;
    logic       exp;
    int lows, low_at, k, pos;
    frame  = {1'b1, data, 1'b0};
    lows   = 0;
    low_at = -1;
    exp    = 1'b1;
    a_txq.delete();
    for (int i = 0; i < 10; i++) a_txq.push_back(frame[i]);
    @(negedge clock);
    a_send = 1'b1; a_tx_data = data;
    @(negedge clock);
    a_send = 1'b0; a_tx_data = ~data;
    for (int c = 1; c <= 660; c++) begin
      if (c > 1) @(negedge clock);
      if (c == 100) a_send = 1'b1;
      if (c == 101) a_send = 1'b0;
      k   = (c - 1) / 64;
      pos = (c - 1) % 64;
      if (k < 10 && (pos == 0 || pos == 63)) begin
        exp = a_txq[0];
        if (pos == 63) void'(a_txq.pop_front());
        total++;
        if (a_txd !== exp) begin
          bad++;
          $display("FAIL tx_bit: data=%h bit=%0d cycle=%0d got txd=%b, required %b", data, k, c, a_txd, exp);
        end
      end
      if (a_ninto === 1'b0) begin lows++; low_at = c; end
      if (c == 1 || c == 640) begin
        total++;
        if (a_busy !== 1'b1) begin bad++; $display("FAIL tx_busy_high: cycle=%0d got %b, required 1", c, a_busy); end
      end
      if (c == 641) begin
        total++;
        if (a_busy !== 1'b0) begin bad++; $display("FAIL tx_busy_release: cycle=641 got %b, required 0", a_busy); end
      end
    end
    total++;
    if (lows != 1 || low_at != 640) begin
      bad++;
      $display("FAIL tx_ninto: got %0d pulses last at cycle %0d, required 1 at cycle 640", lows, low_at);
    end
  endtask

  task automatic test_tx_frame();
    a_lb = 1'b0;
    check_tx_frame(8'hA5);
    repeat (10) @(negedge clock);
  endtask

  task automatic test_loopback();
    int n0;
    n0 = a_ninti_cnt;
    a_lb = 1'b1;
    a_rxq.push_back('{d: 8'h3C, p: 1'b0, f: 1'b0});
    check_tx_frame(8'h3C);
    repeat (20) @(negedge clock);
    total++;
    if (a_ninti_cnt - n0 != 1 || a_rxq.size() != 0) begin
      bad++;
      $display("FAIL loopback_ninti: got %0d pulses, %0d pending, required 1 pulse 0 pending", a_ninti_cnt - n0, a_rxq.size());
    end
    a_lb = 1'b0;
    repeat (10) @(negedge clock);
  endtask

  task automatic test_parity_tx();
    logic [7:0] d;
    logic [9:0] fr;
    int k;
    d  = 8'hFF;
    fr = {1'b1, ^d[6:0], d[6:0], 1'b0};
    b_lb = 1'b1;
    b_rxq.push_back('{d: 8'h7F, p: 1'b0, f: 1'b0});
    @(negedge clock);
    b_send = 1'b1; b_tx_data = d;
    @(negedge clock);
    b_send = 1'b0;
    for (int c = 1; c <= 700; c++) begin
      if (c > 1) @(negedge clock);
      k = (c - 1) / 64;
      if (k < 10 && (c - 1) % 64 == 32) begin
        total++;
        if (b_txd !== fr[k]) begin
          bad++;
          $display("FAIL parity_tx_bit: bit=%0d got %b, required %b", k, b_txd, fr[k]);
        end
      end
      if (c == 641) begin
        total++;
        if (b_busy !== 1'b0) begin bad++; $display("FAIL parity_busy: got %b, required 0", b_busy); end
      end
    end
    total++;
    if (b_rxq.size() != 0) begin bad++; $display("FAIL parity_rx_missing: got %0d pending, required 0", b_rxq.size()); end
    b_lb = 1'b0;
    repeat (10) @(negedge clock);
  endtask

  task automatic drive_rx(input bit which, input logic [9:0] bits);
    for (int i = 0; i < 10; i++) begin
      if (which) b_rxd_drv = bits[i];
      else       a_rxd_drv = bits[i];
      repeat (64) @(negedge clock);
    end
    a_rxd_drv = 1'b1;
    b_rxd_drv = 1'b1;
    repeat (64) @(negedge clock);
  endtask

  task automatic test_parity_error();
    b_rxq.push_back('{d: 8'h7F, p: 1'b1, f: 1'b0});
    drive_rx(1'b1, 10'h2FE);
    total++;
    if (b_rxq.size() != 0) begin bad++; $display("FAIL perr_missing: got %0d pending, required 0", b_rxq.size()); end
  endtask

  task automatic test_framing_error();
    a_rxq.push_back('{d: 8'h55, p: 1'b0, f: 1'b1});
    drive_rx(1'b0, 10'h0AA);
    total++;
    if (a_rxq.size() != 0) begin bad++; $display("FAIL ferr_missing: got %0d pending, required 0", a_rxq.size()); end
  endtask

  task automatic test_glitch();
    int n0;
    n0 = a_ninti_cnt;
    a_rxd_drv = 1'b0;
    repeat (20) @(negedge clock);
    a_rxd_drv = 1'b1;
    repeat (200) @(negedge clock);
    total++;
    if (a_ninti_cnt != n0) begin bad++; $display("FAIL glitch_ninti: got %0d pulses, required 0", a_ninti_cnt - n0); end
    total++;
    if ({a_rx_data, a_rx_perr, a_rx_ferr} !== {8'h55, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL glitch_rx_hold: got data=%h perr=%b ferr=%b, required 55/0/1", a_rx_data, a_rx_perr, a_rx_ferr);
    end
  endtask

  task automatic test_reset_mid_tx();
    int n0;
    @(negedge clock);
    a_send = 1'b1; a_tx_data = 8'h37;
    @(negedge clock);
    a_send = 1'b0;
    repeat (279) @(negedge clock);
    total++;
    if (a_txd !== 1'b0) begin bad++; $display("FAIL mid_tx_bit3: got %b, required 0", a_txd); end
    n0 = a_ninto_cnt;
    #2 reset_n = 1'b0;
    #1;
    total++;
    if ({a_txd, a_busy, a_ninto} !== 3'b101) begin
      bad++;
      $display("FAIL async_reset: got txd/busy/ninto=%b, required 101", {a_txd, a_busy, a_ninto});
    end
    repeat (5) @(negedge clock);
    reset_n = 1'b1;
    repeat (3) @(negedge clock);
    total++;
    if (a_ninto_cnt != n0) begin bad++; $display("FAIL reset_ninto: got %0d pulses, required 0", a_ninto_cnt - n0); end
    check_tx_frame(8'h96);
  endtask

  initial begin
    reset_n   = 1'b0;
    a_send = 1'b0; a_tx_data = 8'h00; a_rxd_drv = 1'b1; a_lb = 1'b0;
    b_send = 1'b0; b_tx_data = 8'h00; b_rxd_drv = 1'b1; b_lb = 1'b0;
    test_reset();
    test_tx_frame();
    test_loopback();
    test_parity_tx();
    test_parity_error();
    test_framing_error();
    test_glitch();
    test_reset_mid_tx();
    repeat (20) @(negedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
